// File: rtl/mem_arbiter2.sv
// Two-master round-robin arbiter for the PicoRV32 native memory interface.
// Optional watchdog abort when MEMARB_TIMEOUT_EN is defined.
module mem_arbiter2 #(
  parameter int FIXED_PRIO = 0,
  parameter int TIMEOUT    = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [1:0]  m_mem_valid,
  input  logic [1:0]  m_mem_instr,
  input  logic [63:0] m_mem_addr,
  input  logic [63:0] m_mem_wdata,
  input  logic [7:0]  m_mem_wstrb,
  output logic [1:0]  m_mem_ready,
  output logic [31:0] m_mem_rdata,
  output logic        s_mem_valid,
  output logic        s_mem_instr,
  output logic [31:0] s_mem_addr,
  output logic [31:0] s_mem_wdata,
  output logic [3:0]  s_mem_wstrb,
  input  logic        s_mem_ready,
  input  logic [31:0] s_mem_rdata,
  output logic        busy,
  output logic        owner,
  output logic        timeout_err
);

  // Handshake: a transaction completes in the cycle where s_mem_valid and
  // s_mem_ready are both high; m_mem_ready mirrors that to the owner only.
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e     state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_q, last_d;
  logic       owner_valid;
  logic       complete;
  logic       timeout_hit;
  logic [1:0] ready_onehot;

`ifdef MEMARB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
  logic [15:0] cnt_q, cnt_d;

  // Held at zero while idle so the first BUSY cycle starts the count at 0.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE)  cnt_d = '0;
    else if (!s_mem_ready) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign timeout_hit = (state_q == BUSY) && owner_valid && !s_mem_ready &&
                       (cnt_q == TIMEOUT_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  assign owner_valid  = m_mem_valid[owner_q];
  assign complete     = (state_q == BUSY) && owner_valid && s_mem_ready;
  assign ready_onehot = owner_q ? 2'b10 : 2'b01;

  assign m_mem_ready  = (complete || timeout_hit) ? ready_onehot : 2'b00;
  assign m_mem_rdata  = timeout_hit ? 32'h0 : s_mem_rdata;
  assign s_mem_valid  = (state_q == BUSY) && owner_valid && !timeout_hit;
  assign busy         = (state_q == BUSY);
  assign owner        = owner_q;
  assign timeout_err  = timeout_hit;

  // Only the owner's fields ever reach the memory side.
  always_comb begin
    s_mem_instr = 1'b0;
    s_mem_addr  = '0;
    s_mem_wdata = '0;
    s_mem_wstrb = '0;
    if (state_q == BUSY) begin
      s_mem_instr = m_mem_instr[owner_q];
      s_mem_addr  = owner_q ? m_mem_addr[63:32]  : m_mem_addr[31:0];
      s_mem_wdata = owner_q ? m_mem_wdata[63:32] : m_mem_wdata[31:0];
      s_mem_wstrb = owner_q ? m_mem_wstrb[7:4]   : m_mem_wstrb[3:0];
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m_mem_valid != 2'b00) begin
          state_d = BUSY;
          if (m_mem_valid == 2'b11) owner_d = (FIXED_PRIO != 0) ? 1'b0 : ~last_q;
          else                      owner_d = m_mem_valid[1];
        end
      end
      BUSY: begin
        // A dropped request abandons the grant without touching priority.
        if (!owner_valid) begin
          state_d = IDLE;
        end else if (complete || timeout_hit) begin
          state_d = IDLE;
          last_d  = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter2.sv
// Scoreboard bench for mem_arbiter2: random masters and memory, with a
// rule-level grant model; optional timeout phase when MEMARB_TIMEOUT_EN is set.
module tb_mem_arbiter2;

`ifdef MEMARB_TIMEOUT_EN
  localparam int TB_TIMEOUT = 8;
`else
  localparam int TB_TIMEOUT = 1024;
`endif
  localparam int MEM_NEVER = 0, MEM_ALWAYS = 1, MEM_LAT = 2, MEM_RANDOM = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  initial forever #10 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        mv[2], mi[2];
  logic [31:0] ma[2], mwd[2];
  logic [3:0]  ms[2];
  logic [1:0]  m_mem_valid, m_mem_instr;
  logic [63:0] m_mem_addr, m_mem_wdata;
  logic [7:0]  m_mem_wstrb;
  logic [1:0]  m_mem_ready;
  logic [31:0] m_mem_rdata;
  logic        s_mem_valid, s_mem_instr;
  logic [31:0] s_mem_addr, s_mem_wdata;
  logic [3:0]  s_mem_wstrb;
  logic        s_mem_ready = 1'b0;
  logic [31:0] s_mem_rdata = '0;
  logic        busy, owner, timeout_err;

  assign m_mem_valid = {mv[1], mv[0]};
  assign m_mem_instr = {mi[1], mi[0]};
  assign m_mem_addr  = {ma[1], ma[0]};
  assign m_mem_wdata = {mwd[1], mwd[0]};
  assign m_mem_wstrb = {ms[1], ms[0]};

  mem_arbiter2 #(.FIXED_PRIO(0), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .resetn(resetn),
    .m_mem_valid(m_mem_valid), .m_mem_instr(m_mem_instr),
    .m_mem_addr(m_mem_addr), .m_mem_wdata(m_mem_wdata), .m_mem_wstrb(m_mem_wstrb),
    .m_mem_ready(m_mem_ready), .m_mem_rdata(m_mem_rdata),
    .s_mem_valid(s_mem_valid), .s_mem_instr(s_mem_instr), .s_mem_addr(s_mem_addr),
    .s_mem_wdata(s_mem_wdata), .s_mem_wstrb(s_mem_wstrb),
    .s_mem_ready(s_mem_ready), .s_mem_rdata(s_mem_rdata),
    .busy(busy), .owner(owner), .timeout_err(timeout_err)
  );

  // Fixed-priority instance, driven independently with both masters always requesting.
  logic [1:0]  f_valid = 2'b00;
  logic        f_ready = 1'b0;
  logic [1:0]  f_m_ready;
  logic [31:0] f_m_rdata, f_s_addr, f_s_wdata;
  logic        f_s_valid, f_s_instr, f_busy, f_owner, f_terr;
  logic [3:0]  f_s_wstrb;

  mem_arbiter2 #(.FIXED_PRIO(1), .TIMEOUT(TB_TIMEOUT)) dut_fixed (
    .clk(clk), .resetn(resetn),
    .m_mem_valid(f_valid), .m_mem_instr(2'b00),
    .m_mem_addr({32'h0000_0002, 32'h0000_0001}), .m_mem_wdata(64'h0), .m_mem_wstrb(8'h0),
    .m_mem_ready(f_m_ready), .m_mem_rdata(f_m_rdata),
    .s_mem_valid(f_s_valid), .s_mem_instr(f_s_instr), .s_mem_addr(f_s_addr),
    .s_mem_wdata(f_s_wdata), .s_mem_wstrb(f_s_wstrb),
    .s_mem_ready(f_ready), .s_mem_rdata(32'h0),
    .busy(f_busy), .owner(f_owner), .timeout_err(f_terr)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [68:0] exp_q0[$];
  logic [68:0] exp_q1[$];
  int          served_q[$];
  logic        in_txn = 1'b0, cur = 1'b0, last_served = 1'b1, prev_done = 1'b0;
  logic        exp_owner, done;
  logic [1:0]  req_prev = 2'b00;
  logic [68:0] got;
  int          busy_cnt = 0, last_lat = 0, to_pulses = 0, f_grants = 0;
  int          mem_mode = MEM_NEVER, mem_lat = 1, lat_cnt = 0;
  logic [31:0] fixed_rdata = '0;

  task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [68:0] pack(input logic instr, input logic [3:0] s,
                                       input logic [31:0] wd, input logic [31:0] a);
    return {instr, s, wd, a};
  endfunction

  // ---------------- driver tasks ----------------
  // Caller is positioned just after a rising edge.
  task automatic do_txn(input int i, input logic instr, input logic [3:0] strb,
                        input logic [31:0] wd, input logic [31:0] a, output logic [31:0] rd);
    bit seen = 0;
    mi[i] = instr; ms[i] = strb; mwd[i] = wd; ma[i] = a; mv[i] = 1'b1;
    if (i == 0) exp_q0.push_back(pack(instr, strb, wd, a));
    else        exp_q1.push_back(pack(instr, strb, wd, a));
    rd = '0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (m_mem_ready[i]) begin seen = 1; rd = m_mem_rdata; break; end
    end
    check($sformatf("m%0d_ready_seen", i), 69'(seen), 69'(1));
    @(posedge clk); #1;
    mv[i] = 1'b0;
  endtask

  task automatic run_master(input int i, input int n, input int gap_max);
    logic [31:0] rd;
    @(posedge clk); #1;
    for (int t = 0; t < n; t++) begin
      int gap = $urandom_range(0, gap_max);
      if (gap > 0) begin repeat (gap) @(posedge clk); #1; end
      do_txn(i, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
             32'($urandom), 32'($urandom), rd);
    end
  endtask

  // ---------------- memory model ----------------
  initial begin
    forever begin
      @(posedge clk); #2;
      s_mem_ready = 1'b0;
      #1;
      if (s_mem_valid) lat_cnt++; else lat_cnt = 0;
      case (mem_mode)
        MEM_ALWAYS: begin s_mem_ready = 1'b1; s_mem_rdata = 32'($urandom); end
        MEM_LAT:    begin s_mem_ready = (lat_cnt == mem_lat); s_mem_rdata = fixed_rdata; end
        MEM_RANDOM: begin s_mem_ready = 1'($urandom_range(0, 1)); s_mem_rdata = 32'($urandom); end
        default:    begin s_mem_ready = 1'b0; s_mem_rdata = fixed_rdata; end
      endcase
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!resetn) begin
      exp_q0.delete(); exp_q1.delete();
      in_txn = 1'b0; last_served = 1'b1; prev_done = 1'b0; req_prev = 2'b00; busy_cnt = 0;
    end else begin
      done = 1'b0;
      if (timeout_err) to_pulses++;
      if (prev_done) check("bubble_after_done", 69'(s_mem_valid), 69'(0));
      if (!in_txn && s_mem_valid) begin
        check("grant_had_request", 69'(req_prev != 2'b00), 69'(1));
        exp_owner = (req_prev == 2'b11) ? ~last_served : req_prev[1];
        check("grant_owner", 69'(owner), 69'(exp_owner));
        got = pack(s_mem_instr, s_mem_wstrb, s_mem_wdata, s_mem_addr);
        if (exp_owner) begin
          check("grant_queue1", 69'(exp_q1.size() != 0), 69'(1));
          if (exp_q1.size() != 0) check("grant_fields1", got, exp_q1[0]);
        end else begin
          check("grant_queue0", 69'(exp_q0.size() != 0), 69'(1));
          if (exp_q0.size() != 0) check("grant_fields0", got, exp_q0[0]);
        end
        cur = exp_owner; in_txn = 1'b1; busy_cnt = 0;
      end
      if (in_txn) begin
        busy_cnt++;
        if (s_mem_ready) begin
          check("ready_onehot", 69'(m_mem_ready), 69'(cur ? 2'b10 : 2'b01));
          check("rdata_pass", 69'(m_mem_rdata), 69'(s_mem_rdata));
          check("no_terr_on_ready", 69'(timeout_err), 69'(0));
          done = 1'b1;
        end
`ifdef MEMARB_TIMEOUT_EN
        else if (busy_cnt == TB_TIMEOUT) begin
          check("to_ready", 69'(m_mem_ready), 69'(cur ? 2'b10 : 2'b01));
          check("to_rdata", 69'(m_mem_rdata), 69'(0));
          check("to_err", 69'(timeout_err), 69'(1));
          check("to_svalid", 69'(s_mem_valid), 69'(0));
          done = 1'b1;
        end
`endif
        else begin
          check("no_early_ready", 69'(m_mem_ready), 69'(0));
          check("valid_held", 69'(s_mem_valid), 69'(1));
        end
        if (done) begin
          if (cur) begin if (exp_q1.size() != 0) void'(exp_q1.pop_front()); end
          else     begin if (exp_q0.size() != 0) void'(exp_q0.pop_front()); end
          served_q.push_back(int'(cur));
          last_served = cur; last_lat = busy_cnt; in_txn = 1'b0;
        end
      end else begin
        check("idle_ready", 69'(m_mem_ready), 69'(0));
        check("idle_terr", 69'(timeout_err), 69'(0));
      end
      prev_done = done;
      req_prev  = m_mem_valid;
    end
  end

  always @(negedge clk) begin
    if (resetn) begin
      if (f_busy) check("fp_owner", 69'(f_owner), 69'(0));
      if (f_m_ready != 2'b00) begin
        check("fp_ready", 69'(f_m_ready), 69'(2'b01));
        f_grants++;
      end
    end
  end

  // ---------------- main sequence ----------------
  logic [31:0] rd0, rd1;

  initial begin
    for (int i = 0; i < 2; i++) begin
      mv[i] = 1'b0; mi[i] = 1'b0; ma[i] = '0; mwd[i] = '0; ms[i] = '0;
    end
    repeat (2) @(negedge clk);
    check("rst_svalid", 69'(s_mem_valid), 69'(0));
    check("rst_mready", 69'(m_mem_ready), 69'(0));
    check("rst_busy", 69'(busy), 69'(0));
    check("rst_owner", 69'(owner), 69'(0));
    check("rst_terr", 69'(timeout_err), 69'(0));
    @(posedge clk); #1;
    resetn = 1'b1;

    // Both masters back-to-back, memory always ready: order 0,1,0,...
    mem_mode = MEM_ALWAYS;
    served_q.delete();
    f_valid = 2'b11; f_ready = 1'b1;
    fork
      run_master(0, 3, 0);
      run_master(1, 3, 0);
    join
    f_valid = 2'b00; f_ready = 1'b0;
    check("rr_count", 69'(served_q.size()), 69'(6));
    if (served_q.size() >= 3) begin
      check("rr_order0", 69'(served_q[0]), 69'(0));
      check("rr_order1", 69'(served_q[1]), 69'(1));
      check("rr_order2", 69'(served_q[2]), 69'(0));
    end
    check("fp_grant_count", 69'(f_grants >= 3), 69'(1));

    // Master 1 write, ready on the 3rd BUSY cycle.
    mem_mode = MEM_LAT; mem_lat = 3; fixed_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    do_txn(1, 1'b0, 4'hF, 32'hDEAD_BEEF, 32'h0000_0100, rd1);
    check("m1_write_latency", 69'(last_lat), 69'(3));

    // Master 0 read, master 1 arrives mid-transaction.
    mem_mode = MEM_LAT; mem_lat = 4; fixed_rdata = 32'h1234_5678;
    served_q.delete();
    @(posedge clk); #1;
    fork
      do_txn(0, 1'b0, 4'h0, 32'h0, 32'h0000_0200, rd0);
      begin repeat (2) @(posedge clk); #1; do_txn(1, 1'b1, 4'h0, 32'h0, 32'h0000_0300, rd1); end
    join
    check("m0_read_data", 69'(rd0), 69'(32'h1234_5678));
    check("held_off_count", 69'(served_q.size()), 69'(2));
    if (served_q.size() >= 2) begin
      check("held_off_first", 69'(served_q[0]), 69'(0));
      check("held_off_second", 69'(served_q[1]), 69'(1));
    end

    // Random traffic on both sides.
    mem_mode = MEM_RANDOM;
    fork
      run_master(0, 25, 3);
      run_master(1, 25, 3);
    join

    // Leave last=0 so a tie right after reset would otherwise favour master 1.
    mem_mode = MEM_LAT; mem_lat = 1;
    @(posedge clk); #1;
    do_txn(0, 1'b0, 4'h3, 32'h5555_AAAA, 32'h0000_0400, rd0);

    // Reset asserted in the middle of a transaction.
    mem_mode = MEM_NEVER;
    @(posedge clk); #1;
    mi[0] = 1'b0; ms[0] = 4'h0; mwd[0] = '0; ma[0] = 32'h0000_0500; mv[0] = 1'b1;
    exp_q0.push_back(pack(1'b0, 4'h0, 32'h0, 32'h0000_0500));
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (busy) break;
    end
    check("rst_mid_busy_reached", 69'(busy), 69'(1));
    @(posedge clk); #5;
    resetn = 1'b0;
    #1;
    check("rst_mid_svalid", 69'(s_mem_valid), 69'(0));
    check("rst_mid_mready", 69'(m_mem_ready), 69'(0));
    check("rst_mid_busy", 69'(busy), 69'(0));
    mv[0] = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    mem_mode = MEM_LAT; mem_lat = 1;
    served_q.delete();
    fork
      do_txn(1, 1'b0, 4'h1, 32'h1, 32'h0000_0600, rd1);
      do_txn(0, 1'b0, 4'h2, 32'h2, 32'h0000_0700, rd0);
    join
    check("post_rst_count", 69'(served_q.size()), 69'(2));
    if (served_q.size() >= 2) begin
      check("post_rst_first", 69'(served_q[0]), 69'(0));
      check("post_rst_second", 69'(served_q[1]), 69'(1));
    end

`ifdef MEMARB_TIMEOUT_EN
    // Memory never answers: both masters are aborted in turn.
    mem_mode = MEM_NEVER;
    served_q.delete();
    to_pulses = 0;
    @(posedge clk); #1;
    fork
      do_txn(0, 1'b0, 4'h0, 32'h0, 32'h0000_0800, rd0);
      do_txn(1, 1'b0, 4'h0, 32'h0, 32'h0000_0900, rd1);
    join
    check("to_pulses", 69'(to_pulses), 69'(2));
    check("to_rd0", 69'(rd0), 69'(0));
    check("to_rd1", 69'(rd1), 69'(0));
    if (served_q.size() >= 2) begin
      check("to_first", 69'(served_q[0]), 69'(0));
      check("to_second", 69'(served_q[1]), 69'(1));
    end
`endif

    repeat (4) @(posedge clk);
    check("drain_q0", 69'(exp_q0.size()), 69'(0));
    check("drain_q1", 69'(exp_q1.size()), 69'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
